pulse_train_gen: RTL and testbench
==================================

# pulse_train_gen

Clocked pulse-train generator that emits a programmed number of pulses with programmed high and low widths, then latches a completion flag until restarted or reset. It is the transmitting end of the pulse-counting path. Its `gen_pulse_out` drives the count input of the 32-bit target counter, and `gen_count` is normally the same value loaded into that counter's target. The block sits in the divider fabric on the system clock.

## Interface
- `CNT_W`, default 32: width of the pulse-count and pulses-sent fields.
- `PHASE_W`, default 16: width of the high-phase and low-phase width fields.

Ports:
- `gen_clk`  in  1  system clock; all logic on the rising edge.
- `gen_reset`  in  1  synchronous reset, active-high.
- `gen_start`  in  1  starts a burst; level-sampled, acted on only in IDLE or DONE.
- `gen_enable`  in  1  high: burst advances; low: burst freezes in place.
- `gen_count`  in  CNT_W  number of pulses per burst; latched on start.
- `gen_high`  in  PHASE_W  high width in clocks; latched on start; 0 is treated as 1.
- `gen_low`  in  PHASE_W  low width in clocks; latched on start; 0 is treated as 1.
- `gen_pulse_out`  out  1  registered pulse output.
- `gen_busy`  out  1  high while in HIGH or LOW state.
- `gen_completed`  out  1  sticky done flag.
- `gen_pulses_sent`  out  CNT_W  rising edges emitted in the current or last burst.

## Operation
- States:
  - IDLE: reset state.
  - HIGH and LOW: active burst.
  - DONE: burst finished.
- IDLE or DONE, on `gen_start`=1:
  - Latch `gen_count`, `gen_high` and `gen_low`.
  - Clear `gen_pulses_sent` and `gen_completed`.
  - If the latched count is nonzero: load the phase counter with the high width, go to HIGH, and set `gen_pulses_sent` to 1.
- Latched count 0: behaviour is set by the macro (see Configuration).
- HIGH: `gen_pulse_out`=1. When the phase counter expires, load the low width and go to LOW.
- LOW: `gen_pulse_out`=0. When the phase counter expires:
  - If pulses sent equals the latched count: go to DONE and set `gen_completed`.
  - Otherwise: go to HIGH and increment `gen_pulses_sent`.
- The counter increments only when entering HIGH, so it always equals the number of rising edges emitted.
- `gen_enable`=0 in HIGH or LOW: hold state, phase counter, `gen_pulse_out` and `gen_pulses_sent`. Phases stretch by the stalled cycles.
- `gen_enable` has no effect in IDLE or DONE.
- `gen_start` in HIGH or LOW is ignored. Input changes mid-burst have no effect.
- `gen_start` held high in DONE restarts a burst on every DONE visit. `gen_completed` is then high for exactly one cycle per burst.
- `gen_reset` overrides everything, including mid-burst: return to IDLE with all outputs 0.
- Arithmetic:
  - Phase counters are PHASE_W wide, unsigned, and count down to 1.
  - `gen_pulses_sent` does not wrap: the maximum count is 2^CNT_W−1.

## Timing
- Reset values: `gen_pulse_out`=0, `gen_busy`=0, `gen_completed`=0, `gen_pulses_sent`=0, state IDLE.
- Start sampled at edge k (enable held high):
  - `gen_pulse_out` rises in cycle k+1.
  - Each pulse is H cycles high, then L cycles low.
- Burst length is N·(H+L) cycles. `gen_busy` is high in cycles k+1 through k+N·(H+L).
- `gen_completed` rises in cycle k+1+N·(H+L) and holds until the next accepted start or reset.
- The final low phase always completes before DONE. The downstream counter therefore sees a low level after its last edge.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- `PULSE_TRAIN_CONTINUOUS_EN` defined:
  - Latched count 0 means free-run: HIGH/LOW alternate indefinitely and DONE is never reached.
  - `gen_pulses_sent` saturates at 2^CNT_W−1.
  - Exit is only via `gen_reset`.
- `PULSE_TRAIN_CONTINUOUS_EN` undefined:
  - Latched count 0 goes straight to DONE with no pulse.
  - `gen_completed`=1 in cycle k+1, and `gen_busy` never rises.

## Test plan
- N=3, H=2, L=3, start at cycle 10:
  - `gen_pulse_out` high in cycles 11–12, 16–17 and 21–22.
  - `gen_busy` high in cycles 11–25.
  - `gen_completed`=1 from cycle 26; `gen_pulses_sent`=3.
- N=2, H=0, L=0:
  - Widths are treated as 1, giving out pattern 1,0,1,0.
  - `gen_completed` rises 4 cycles after the start edge.
- N=2, H=4, L=1, `gen_enable` low for 5 cycles during the first high phase:
  - The first pulse is 9 cycles wide.
  - Completion is delayed by exactly 5 cycles; the count is still 2.
- Mid-burst disturbances, N=5:
  - Pulse `gen_start` during pulse 2: ignored, and the burst still ends at 5.
  - Assert `gen_reset` during pulse 4: all outputs 0 on the next cycle and state IDLE.
  - Restart after reset: a full burst of 5.
- N=0, macro undefined: `gen_completed`=1 one cycle after start, with no pulse.
- N=0, macro defined: 100 continuous pulses are observed and `gen_completed` stays 0 until reset.

Source files
------------

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits N pulses of programmed high/low width, then holds a sticky done flag (free-run on count 0 with PULSE_TRAIN_CONTINUOUS_EN)
module pulse_train_gen #(
  parameter int CNT_W   = 32,
  parameter int PHASE_W = 16
) (
  input  logic               gen_clk,
  input  logic               gen_reset,
  input  logic               gen_start,
  input  logic               gen_enable,
  input  logic [CNT_W-1:0]   gen_count,
  input  logic [PHASE_W-1:0] gen_high,
  input  logic [PHASE_W-1:0] gen_low,
  output logic               gen_pulse_out,
  output logic               gen_busy,
  output logic               gen_completed,
  output logic [CNT_W-1:0]   gen_pulses_sent
);
  localparam logic [1:0] IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2, DONE = 2'd3;
`ifdef PULSE_TRAIN_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif
  localparam logic [PHASE_W-1:0] ONE = PHASE_W'(1);
  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt_lat;
  logic [PHASE_W-1:0] high_lat, low_lat, phase, high_in, low_in;
  logic               last;
  assign high_in = gen_high == '0 ? ONE : gen_high;
  assign low_in  = gen_low == '0 ? ONE : gen_low;
  // a zero latched count never terminates in free-run mode
  assign last = (!CONT || cnt_lat != '0) && gen_pulses_sent == cnt_lat;
  always_ff @(posedge gen_clk) begin
    if (gen_reset) begin
      state           <= IDLE;
      cnt_lat         <= '0;
      high_lat        <= '0;
      low_lat         <= '0;
      phase           <= '0;
      gen_pulse_out   <= 1'b0;
      gen_busy        <= 1'b0;
      gen_completed   <= 1'b0;
      gen_pulses_sent <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (gen_start) begin
          cnt_lat       <= gen_count;
          high_lat      <= high_in;
          low_lat       <= low_in;
          gen_completed <= 1'b0;
          if (CONT || gen_count != '0) begin
            state           <= HIGH;
            phase           <= high_in;
            gen_pulse_out   <= 1'b1;
            gen_busy        <= 1'b1;
            gen_pulses_sent <= CNT_W'(1);
          end else begin
            state           <= DONE;
            gen_completed   <= 1'b1;
            gen_pulses_sent <= '0;
          end
        end
        HIGH: if (gen_enable) begin
          if (phase == ONE) begin
            state         <= LOW;
            phase         <= low_lat;
            gen_pulse_out <= 1'b0;
          end else phase <= phase - ONE;
        end
        LOW: if (gen_enable) begin
          if (phase != ONE) phase <= phase - ONE;
          else if (last) begin
            state         <= DONE;
            gen_busy      <= 1'b0;
            gen_completed <= 1'b1;
          end else begin
            state           <= HIGH;
            phase           <= high_lat;
            gen_pulse_out   <= 1'b1;
            gen_pulses_sent <= gen_pulses_sent + CNT_W'(gen_pulses_sent != '1);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: randomized bursts checked against a progress-index model of the pulse train
module tb_pulse_train_gen;
  localparam int CNT_W = 32, PHASE_W = 16;
  logic               gen_clk, gen_reset, gen_start, gen_enable;
  logic [CNT_W-1:0]   gen_count;
  logic [PHASE_W-1:0] gen_high, gen_low;
  logic               gen_pulse_out, gen_busy, gen_completed;
  logic [CNT_W-1:0]   gen_pulses_sent;
  int total_n = 0, bad_n = 0;

  pulse_train_gen #(.CNT_W(CNT_W), .PHASE_W(PHASE_W)) dut (
    .gen_clk(gen_clk), .gen_reset(gen_reset), .gen_start(gen_start), .gen_enable(gen_enable),
    .gen_count(gen_count), .gen_high(gen_high), .gen_low(gen_low),
    .gen_pulse_out(gen_pulse_out), .gen_busy(gen_busy), .gen_completed(gen_completed),
    .gen_pulses_sent(gen_pulses_sent)
  );

  initial gen_clk = 1'b0;
  always #5 gen_clk = ~gen_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge gen_clk);
    #1;
  endtask

  // Expected outputs from the burst progress index t (cycles of enabled advance since start)
  function automatic logic [CNT_W+2:0] model(input int t, input int n, input int hh, input int ll, input bit endless);
    int p = hh + ll;
    if (endless || t < n * p)
      return {1'b1 ? ((t % p) < hh) : 1'b0, 1'b1, 1'b0, CNT_W'(t / p + 1)};
    return {1'b0, 1'b0, 1'b1, CNT_W'(n)};
  endfunction

  task automatic run_burst(input int n, input int h, input int l, input int sa, input int sl, input int sp, input string name);
    int hh = (h == 0) ? 1 : h;
    int ll = (l == 0) ? 1 : l;
    int total = n * (hh + ll);
    int t = 0;
    logic [CNT_W+2:0] exp_v, got_v;
    gen_count = CNT_W'(n); gen_high = PHASE_W'(h); gen_low = PHASE_W'(l);
    gen_start = 1'b1; gen_enable = 1'b1;
    tick();
    gen_start = 1'b0;
    gen_count = $urandom; gen_high = PHASE_W'($urandom); gen_low = PHASE_W'($urandom);
    for (int i = 0; i < total + sl + 3; i++) begin
      exp_v = model(t, n, hh, ll, 1'b0);
      got_v = {gen_pulse_out, gen_busy, gen_completed, gen_pulses_sent};
      total_n++;
      if (got_v !== exp_v) begin
        bad_n++;
        $display("FAIL %s cycle %0d: out/busy/done/sent got %b/%b/%b/%0d want %b/%b/%b/%0d", name, i,
                 got_v[CNT_W+2], got_v[CNT_W+1], got_v[CNT_W], got_v[CNT_W-1:0],
                 exp_v[CNT_W+2], exp_v[CNT_W+1], exp_v[CNT_W], exp_v[CNT_W-1:0]);
      end
      gen_enable = !(i >= sa && i < sa + sl);
      gen_start = (i == sp);
      tick();
      if (gen_enable && t < total) t++;
    end
    gen_enable = 1'b1; gen_start = 1'b0;
  endtask

  task automatic check_idle(input string name);
    total_n++;
    if ({gen_pulse_out, gen_busy, gen_completed, gen_pulses_sent} !== '0) begin
      bad_n++;
      $display("FAIL %s: out/busy/done/sent got %b/%b/%b/%0d want 0/0/0/0", name,
               gen_pulse_out, gen_busy, gen_completed, gen_pulses_sent);
    end
  endtask

  task automatic test_reset();
    gen_reset = 1'b1; gen_start = 1'b0; gen_enable = 1'b1;
    gen_count = '0; gen_high = '0; gen_low = '0;
    tick(); tick();
    check_idle("reset");
    gen_reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check_idle("idle_after_reset");
  endtask

  task automatic test_basic();
    run_burst(3, 2, 3, -1, 0, -1, "n3_h2_l3");
    run_burst(2, 0, 0, -1, 0, -1, "zero_widths");
    run_burst(1, 1, 1, -1, 0, -1, "single_min");
  endtask

  task automatic test_stall();
    run_burst(2, 4, 1, 1, 5, -1, "stall_first_high");
    run_burst(3, 2, 2, 6, 3, -1, "stall_low");
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      int n = $urandom_range(1, 6);
      int h = $urandom_range(0, 5);
      int l = $urandom_range(0, 5);
      run_burst(n, h, l, $urandom_range(0, 15), $urandom_range(0, 4), $urandom_range(0, 10), "random");
    end
  endtask

  task automatic test_disturb();
    int found = 0;
    run_burst(5, 2, 2, -1, 0, 5, "start_mid_burst");
    gen_count = 5; gen_high = 2; gen_low = 2; gen_start = 1'b1;
    tick();
    gen_start = 1'b0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      if (gen_pulses_sent == 4 && gen_pulse_out) found = 1;
      else tick();
    end
    total_n++;
    if (found == 0) begin
      bad_n++;
      $display("FAIL reach_pulse4: sent got %0d want 4 within 100 cycles", gen_pulses_sent);
    end
    gen_reset = 1'b1;
    tick();
    check_idle("reset_mid_burst");
    gen_reset = 1'b0;
    tick();
    check_idle("idle_after_mid_reset");
    run_burst(5, 2, 2, -1, 0, -1, "restart_after_reset");
  endtask

  task automatic test_back_to_back();
    int n = 2, hh = 2, ll = 1;
    int total = n * (hh + ll);
    int ones = 0;
    logic [CNT_W+2:0] exp_v;
    gen_count = CNT_W'(n); gen_high = PHASE_W'(hh); gen_low = PHASE_W'(ll); gen_start = 1'b1;
    tick();
    for (int i = 0; i < 3 * (total + 1); i++) begin
      int c = i % (total + 1);
      exp_v = model(c, n, hh, ll, 1'b0);
      if (gen_completed) ones++;
      total_n++;
      if ({gen_pulse_out, gen_busy, gen_completed, gen_pulses_sent} !== exp_v) begin
        bad_n++;
        $display("FAIL back_to_back cycle %0d: out/busy/done/sent got %b/%b/%b/%0d want %b/%b/%b/%0d", i,
                 gen_pulse_out, gen_busy, gen_completed, gen_pulses_sent,
                 exp_v[CNT_W+2], exp_v[CNT_W+1], exp_v[CNT_W], exp_v[CNT_W-1:0]);
      end
      tick();
    end
    gen_start = 1'b0;
    total_n++;
    if (ones != 3) begin
      bad_n++;
      $display("FAIL back_to_back_done_count: got %0d want 3", ones);
    end
    for (int i = 0; i < total + 2; i++) tick();
  endtask

  task automatic test_zero_count();
`ifdef PULSE_TRAIN_CONTINUOUS_EN
    int hh = $urandom_range(1, 3);
    int ll = $urandom_range(1, 3);
    logic [CNT_W+2:0] exp_v;
    gen_count = '0; gen_high = PHASE_W'(hh); gen_low = PHASE_W'(ll); gen_start = 1'b1;
    tick();
    gen_start = 1'b0;
    for (int t = 0; t < 100 * (hh + ll) + 2; t++) begin
      exp_v = model(t, 0, hh, ll, 1'b1);
      total_n++;
      if ({gen_pulse_out, gen_busy, gen_completed, gen_pulses_sent} !== exp_v) begin
        bad_n++;
        $display("FAIL free_run cycle %0d: out/busy/done/sent got %b/%b/%b/%0d want %b/%b/%b/%0d", t,
                 gen_pulse_out, gen_busy, gen_completed, gen_pulses_sent,
                 exp_v[CNT_W+2], exp_v[CNT_W+1], exp_v[CNT_W], exp_v[CNT_W-1:0]);
      end
      tick();
    end
    gen_reset = 1'b1;
    tick();
    check_idle("free_run_reset");
    gen_reset = 1'b0;
    tick();
`else
    run_burst(0, 3, 2, -1, 0, -1, "zero_count");
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_disturb();
    test_back_to_back();
    test_zero_count();
    run_burst(2, 1, 2, -1, 0, -1, "after_zero_count");
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule
